// File: rtl/ifid_decode_reg.sv
// ---------------------------------------------------------------------------
// ifid_decode_reg
//   IF/ID pipeline stage. Fetched {pc, instr} beats are registered behind a
//   valid/ready handshake. A main register drives the outputs and a skid
//   register absorbs the single beat that can arrive while the main register
//   is stalled, so in_ready is a pure register output.
//   The main instruction is split into MIPS fields and an extension-mode
//   code is decoded for the downstream 16->32 immediate extender.
//
// Ports
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   : upstream handshake
//   in_pc, in_instr     : fetched beat
//   flush               : drop every held beat (taken branch/jump)
//   out_valid/out_ready : downstream handshake
//   out_pc, out_instr   : registered beat
//   out_op .. out_funct : MIPS field slices of out_instr
//   out_imm16           : instr[15:0] for the extender
//   out_ext_sel         : 00 sign, 01 zero, 10 upper (imm<<16)
// ---------------------------------------------------------------------------
module ifid_decode_reg #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [5:0]         out_op,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_shamt,
    output logic [5:0]         out_funct,
    output logic [15:0]        out_imm16,
    output logic [1:0]         out_ext_sel
);

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    logic               main_valid_reg;
    logic [PC_W-1:0]    main_pc_reg;
    logic [INSTR_W-1:0] main_instr_reg;
    logic               skid_valid_reg;
    logic [PC_W-1:0]    skid_pc_reg;
    logic [INSTR_W-1:0] skid_instr_reg;

    logic accept;
    logic emit;

    // in_ready depends only on the skid register, never on out_ready.
    assign in_ready  = !skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign accept    = in_valid && in_ready;
    assign emit      = main_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            main_pc_reg    <= '0;
            main_instr_reg <= '0;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= '0;
            skid_instr_reg <= '0;
        end else if (flush) begin
            // Data registers keep stale contents; only validity is cleared.
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (emit) begin
            if (skid_valid_reg) begin
                // Skid beat is older than anything upstream; it goes next.
                // No accept is possible here because in_ready is low.
                main_pc_reg    <= skid_pc_reg;
                main_instr_reg <= skid_instr_reg;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                main_pc_reg    <= in_pc;
                main_instr_reg <= in_instr;
            end else begin
                main_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid_reg) begin
                // Main is stalled: park the beat and drop in_ready.
                skid_pc_reg    <= in_pc;
                skid_instr_reg <= in_instr;
                skid_valid_reg <= 1'b1;
            end else begin
                main_pc_reg    <= in_pc;
                main_instr_reg <= in_instr;
                main_valid_reg <= 1'b1;
            end
        end
    end

    assign out_pc    = main_pc_reg;
    assign out_instr = main_instr_reg;
    assign out_op    = main_instr_reg[31:26];
    assign out_rs    = main_instr_reg[25:21];
    assign out_rt    = main_instr_reg[20:16];
    assign out_rd    = main_instr_reg[15:11];
    assign out_shamt = main_instr_reg[10:6];
    assign out_funct = main_instr_reg[5:0];
    assign out_imm16 = main_instr_reg[15:0];

    // Logical immediates are zero-extended, lui shifts up, everything else
    // (arithmetic, loads/stores, branches) sign-extends.
    always_comb begin
        out_ext_sel = EXT_SIGN;
        case (main_instr_reg[31:26])
            OP_ANDI, OP_ORI, OP_XORI: out_ext_sel = EXT_ZERO;
            OP_LUI:                   out_ext_sel = EXT_UPPER;
            default:                  out_ext_sel = EXT_SIGN;
        endcase
    end

endmodule
